// File: rtl/ft_test_pkg.sv
// ft_test_pkg: shared states, command codes, frame markers, result words and LFSR taps
package ft_test_pkg;
  typedef enum logic [2:0] {CMD_WAIT, CMD_READ, CMD_PARSE, TX_TEST, RX_TEST, RX_REPORT, STAT_SEND} state_t;
  typedef enum logic [1:0] {MODE_INC, MODE_LFSR, MODE_WALK, MODE_INC3} mode_t;
  localparam logic [7:0] FRAME_PREFIX = 8'hAA;
  localparam logic [7:0] FRAME_SUFFIX = 8'h55;
  localparam logic [15:0] CODE_TX = 16'hBEEF;
  localparam logic [15:0] CODE_RX = 16'hCAFE;
  localparam logic [15:0] CODE_LED = 16'h1ED0;
  localparam logic [15:0] CODE_MODE = 16'h0DE5;
  localparam logic [15:0] CODE_STAT = 16'h57A7;
  localparam logic [7:0] WORD_PASS = 8'h42;
  localparam logic [7:0] WORD_FAIL = 8'hEE;
  localparam logic [31:0] LFSR_TAPS_8 = 32'h0000_00B8;
  localparam logic [31:0] LFSR_TAPS_16 = 32'h0000_B400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;
  function automatic logic [31:0] lfsr_taps(input int w);
    return w == 8 ? LFSR_TAPS_8 : w == 16 ? LFSR_TAPS_16 : LFSR_TAPS_32;
  endfunction
endpackage

// File: rtl/ft_pattern_gen.sv
// ft_pattern_gen: pattern register with seed load and per-mode advance
module ft_pattern_gen
  import ft_test_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              adv,
  input  mode_t             mode,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] value
);
  localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));
  logic [DATA_W-1:0] value_q, value_d, seed_fix, nxt;
  // LFSR and walking-ones would lock up on zero, so a zero seed becomes 1 for them
  always_comb begin
    seed_fix = (mode == MODE_LFSR || mode == MODE_WALK) && seed == '0 ? DATA_W'(1) : seed;
    nxt = mode == MODE_LFSR ? (value_q >> 1) ^ (value_q[0] ? TAPS : '0) :
          mode == MODE_WALK ? {value_q[DATA_W-2:0], value_q[DATA_W-1]} : value_q + DATA_W'(1);
    value_d = load ? seed_fix : adv ? nxt : value_q;
  end
  // pattern state register
  always_ff @(posedge clk or posedge rst)
    if (rst) value_q <= DATA_W'(1);
    else value_q <= value_d;
  assign value = value_q;
endmodule

// File: rtl/ft_test_engine.sv
// ft_test_engine: FIFO command parser driving TX/RX pattern tests, LED and status reports
module ft_test_engine
  import ft_test_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LED_W = 4,
  parameter int CNT_W = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              rxfifo_empty,
  output logic              rxfifo_rd,
  input  logic              rxfifo_valid,
  input  logic [DATA_W-1:0] rxfifo_data,
  input  logic              txfifo_full,
  output logic              txfifo_wr,
  output logic [DATA_W-1:0] txfifo_data,
  output logic [LED_W-1:0]  led,
  output logic              busy
);
  state_t state_q, state_d;
  mode_t mode_q, mode_d;
  logic [63:0] win_q, win_d;
  logic [DATA_W-1:0] seed_q, seed_d, txd_q, txd_d, tx_val, rx_val, cur_w, nxt_w;
  logic [LED_W-1:0] led_q, led_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, n_q, n_d, iss_q, iss_d, err_q, err_d;
  logic [31:0] err_w;
  logic [1:0] idx_n;
  logic wr_q, wr_d, rd, last, frame_ok, tx_load, tx_adv, rx_load, rx_adv;
  ft_pattern_gen #(.DATA_W(DATA_W)) u_tx_gen (
    .clk(sys_clk), .rst(sys_rst), .load(tx_load), .adv(tx_adv), .mode(mode_q), .seed(seed_q), .value(tx_val)
  );
  ft_pattern_gen #(.DATA_W(DATA_W)) u_rx_gen (
    .clk(sys_clk), .rst(sys_rst), .load(rx_load), .adv(rx_adv), .mode(mode_q), .seed(seed_q), .value(rx_val)
  );
  // Window is little-endian in arrival order: first byte (prefix) ends up at [7:0].
  // The TX generator runs one word ahead of txfifo_data, so its value is always the next word.
  always_comb begin
    state_d = state_q;
    win_d = win_q;
    mode_d = mode_q;
    seed_d = seed_q;
    led_d = led_q;
    wr_d = wr_q;
    txd_d = txd_q;
    cnt_d = cnt_q;
    n_d = n_q;
    iss_d = iss_q;
    err_d = err_q;
    rd = 1'b0;
    tx_load = 1'b0;
    tx_adv = 1'b0;
    rx_load = 1'b0;
    rx_adv = 1'b0;
    frame_ok = win_q[7:0] == FRAME_PREFIX && win_q[63:56] == FRAME_SUFFIX;
    err_w = 32'(err_q);
    idx_n = cnt_q[1:0] + 2'd1;
    cur_w = state_q == RX_REPORT ? (err_q == '0 ? DATA_W'(WORD_PASS) : DATA_W'(WORD_FAIL)) :
            state_q == STAT_SEND ? DATA_W'(err_w[{cnt_q[1:0], 3'b000} +: 8]) : tx_val;
    nxt_w = state_q == STAT_SEND ? DATA_W'(err_w[{idx_n, 3'b000} +: 8]) : tx_val;
    last = state_q == RX_REPORT || (state_q == STAT_SEND ? cnt_q[1:0] == 2'd3 : cnt_q == n_q - CNT_W'(1));
    case (state_q)
      CMD_WAIT: begin
        rd = !rxfifo_empty;
        if (rd) state_d = CMD_READ;
      end
      CMD_READ:
        if (rxfifo_valid) begin
          win_d = {rxfifo_data[7:0], win_q[63:8]};
          state_d = CMD_PARSE;
        end
      CMD_PARSE: begin
        state_d = CMD_WAIT;
        if (frame_ok) begin
          win_d = '0;
          cnt_d = '0;
          iss_d = '0;
          n_d = win_q[24 +: CNT_W];
          case (win_q[23:8])
            CODE_TX: begin
              tx_load = 1'b1;
              if (n_d != '0) state_d = TX_TEST;
            end
            CODE_RX: begin
              rx_load = 1'b1;
              err_d = '0;
              state_d = n_d == '0 ? RX_REPORT : RX_TEST;
            end
            CODE_LED: led_d = win_q[24 +: LED_W];
            CODE_MODE: begin
              mode_d = mode_t'(win_q[25:24]);
              seed_d = win_q[24 +: DATA_W];
            end
            CODE_STAT: state_d = STAT_SEND;
            default: ;
          endcase
        end
      end
      RX_TEST: begin
        rd = !rxfifo_empty && iss_q != n_q;
        if (rd) iss_d = iss_q + CNT_W'(1);
        if (rxfifo_valid) begin
          rx_adv = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (rxfifo_data != rx_val && err_q != '1) err_d = err_q + CNT_W'(1);
          if (cnt_q == n_q - CNT_W'(1)) state_d = RX_REPORT;
        end
      end
      TX_TEST, RX_REPORT, STAT_SEND:
        if (!wr_q) begin
          wr_d = 1'b1;
          txd_d = cur_w;
          tx_adv = state_q == TX_TEST;
        end else if (!txfifo_full) begin
          if (last) begin
            wr_d = 1'b0;
            state_d = CMD_WAIT;
          end else begin
            txd_d = nxt_w;
            cnt_d = cnt_q + CNT_W'(1);
            tx_adv = state_q == TX_TEST;
          end
        end
      default: state_d = CMD_WAIT;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      state_q <= CMD_WAIT;
      win_q <= '0;
      mode_q <= MODE_INC;
      seed_q <= DATA_W'(1);
      led_q <= '0;
      wr_q <= 1'b0;
      txd_q <= '0;
      cnt_q <= '0;
      n_q <= '0;
      iss_q <= '0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      win_q <= win_d;
      mode_q <= mode_d;
      seed_q <= seed_d;
      led_q <= led_d;
      wr_q <= wr_d;
      txd_q <= txd_d;
      cnt_q <= cnt_d;
      n_q <= n_d;
      iss_q <= iss_d;
      err_q <= err_d;
    end
  assign rxfifo_rd = rd && !sys_rst;
  assign txfifo_wr = wr_q;
  assign txfifo_data = txd_q;
  assign led = led_q;
  assign busy = state_q != CMD_WAIT;
endmodule

// File: tb/tb_ft_test_engine.sv
// tb_ft_test_engine: randomized FIFO-driven check of ft_test_engine against a pattern model
module tb_ft_test_engine;
  logic sys_clk = 0, sys_rst = 0, rxfifo_empty = 1, rxfifo_valid = 0, txfifo_full = 0;
  logic [7:0] rxfifo_data = 0;
  logic rxfifo_rd, txfifo_wr, busy;
  logic [7:0] txfifo_data;
  logic [3:0] led;
  int total = 0, bad = 0, full_mode = 0;
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic prev_stall = 0;
  logic [7:0] prev_data = 0;
  logic [1:0] m_mode = 0;
  logic [7:0] m_seed = 1;
  logic [3:0] m_led = 0;
  int m_err = 0;

  ft_test_engine dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rxfifo_empty(rxfifo_empty), .rxfifo_rd(rxfifo_rd),
    .rxfifo_valid(rxfifo_valid), .rxfifo_data(rxfifo_data), .txfifo_full(txfifo_full),
    .txfifo_wr(txfifo_wr), .txfifo_data(txfifo_data), .led(led), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_word(input logic [1:0] m, input logic [7:0] s, input int k);
    logic [7:0] v;
    int r;
    v = (m == 1 || m == 2) && s == 0 ? 8'd1 : s;
    r = k % 8;
    if (m == 2) return 8'((v << r) | (v >> (8 - r)));
    if (m == 1) begin
      for (int i = 0; i < k; i++) v = v[0] ? (v >> 1) ^ 8'hB8 : v >> 1;
      return v;
    end
    return 8'(s + k);
  endfunction

  task automatic step();
    logic did_rd, did_wr;
    logic [7:0] d;
    @(negedge sys_clk);
    if (prev_stall) begin
      chk("hold_wr", txfifo_wr, 1);
      chk("hold_data", txfifo_data, prev_data);
    end
    chk("rd_when_empty", rxfifo_rd && rxfifo_empty, 0);
    did_rd = rxfifo_rd && !rxfifo_empty;
    did_wr = txfifo_wr && !txfifo_full;
    prev_stall = txfifo_wr && txfifo_full && !sys_rst;
    prev_data = txfifo_data;
    d = txfifo_data;
    @(posedge sys_clk);
    #1;
    if (did_wr) txq.push_back(d);
    rxfifo_valid = did_rd;
    if (did_rd) rxfifo_data = rxq.pop_front();
    rxfifo_empty = rxq.size() == 0;
    txfifo_full = full_mode == 1 ? !txfifo_full : full_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic run_idle(input string tag);
    int quiet = 0, n = 0;
    while (quiet < 4 && n < 3000) begin
      step();
      n++;
      quiet = (rxq.size() == 0 && !busy && !rxfifo_valid && !txfifo_wr) ? quiet + 1 : 0;
    end
    chk({tag, "_timeout"}, n < 3000, 1);
  endtask

  task automatic push_frame(input logic [15:0] code, input logic [31:0] data);
    rxq.push_back(8'hAA);
    rxq.push_back(code[7:0]);
    rxq.push_back(code[15:8]);
    for (int i = 0; i < 4; i++) rxq.push_back(8'(data >> (8 * i)));
    rxq.push_back(8'h55);
    rxfifo_empty = 0;
  endtask

  task automatic do_mode(input logic [31:0] d);
    txq.delete();
    push_frame(16'h0DE5, d);
    run_idle("mode");
    m_mode = d[1:0];
    m_seed = d[7:0];
    chk("mode_no_tx", txq.size(), 0);
  endtask

  task automatic do_led(input logic [31:0] d);
    push_frame(16'h1ED0, d);
    run_idle("led");
    m_led = d[3:0];
    chk("led", led, m_led);
  endtask

  task automatic do_tx(input int n);
    txq.delete();
    push_frame(16'hBEEF, n);
    run_idle("tx");
    chk("tx_count", txq.size(), n);
    for (int k = 0; k < n && k < txq.size(); k++) chk($sformatf("tx_word%0d", k), txq[k], model_word(m_mode, m_seed, k));
    chk("tx_busy_idle", busy, 0);
  endtask

  task automatic do_rx(input int n, input logic [31:0] mask, input logic [7:0] xv, input bit garbage);
    logic [7:0] w;
    txq.delete();
    m_err = 0;
    if (garbage) rxq.push_back(8'h11);
    push_frame(16'hCAFE, n);
    for (int k = 0; k < n; k++) begin
      w = model_word(m_mode, m_seed, k);
      if (mask[k] && xv != 0) begin
        w ^= xv;
        m_err++;
      end
      rxq.push_back(w);
    end
    run_idle("rx");
    chk("rx_count", txq.size(), 1);
    if (txq.size() > 0) chk("rx_report", txq[0], m_err == 0 ? 8'h42 : 8'hEE);
  endtask

  task automatic do_stat();
    txq.delete();
    push_frame(16'h57A7, 0);
    run_idle("stat");
    chk("stat_count", txq.size(), 4);
    for (int k = 0; k < 4 && k < txq.size(); k++) chk($sformatf("stat_byte%0d", k), txq[k], 8'(m_err >> (8 * k)));
  endtask

  initial begin
    #1 sys_rst = 1;
    rxfifo_empty = 0;
    #1;
    chk("rst_rd", rxfifo_rd, 0);
    chk("rst_wr", txfifo_wr, 0);
    chk("rst_data", txfifo_data, 0);
    chk("rst_led", led, 0);
    chk("rst_busy", busy, 0);
    rxfifo_empty = 1;
    repeat (2) step();
    #2 sys_rst = 0;
    do_tx(3);
    do_mode(32'h0000_0000);
    do_tx(5);
    do_rx(3, 0, 0, 1);
    do_rx(3, 32'h2, 8'hFE, 0);
    do_stat();
    do_mode(32'h0000_0001);
    do_tx(3);
    full_mode = 1;
    do_tx(4);
    full_mode = 0;
    do_tx(0);
    do_rx(0, 0, 0, 0);
    do_led(32'h0000_000A);
    txq.delete();
    push_frame(16'h1234, 32'h0000_0007);
    run_idle("unknown");
    chk("unknown_no_tx", txq.size(), 0);
    chk("unknown_led", led, m_led);
    for (int it = 0; it < 6; it++) begin
      full_mode = $urandom_range(0, 2);
      do_mode($urandom);
      do_tx($urandom_range(1, 12));
      do_rx($urandom_range(1, 8), $urandom, 8'($urandom_range(0, 255)), it[0]);
      do_stat();
      do_led($urandom);
    end
    full_mode = 0;
    txq.delete();
    push_frame(16'hCAFE, 10);
    rxq.push_back(8'h00);
    rxq.push_back(8'h01);
    repeat (40) step();
    chk("midrx_busy", busy, 1);
    #2 sys_rst = 1;
    rxfifo_empty = 0;
    #1;
    chk("midrx_rd", rxfifo_rd, 0);
    chk("midrx_wr", txfifo_wr, 0);
    chk("midrx_data", txfifo_data, 0);
    chk("midrx_led", led, 0);
    chk("midrx_busy0", busy, 0);
    rxq.delete();
    rxfifo_empty = 1;
    rxfifo_valid = 0;
    prev_stall = 0;
    repeat (3) step();
    #2 sys_rst = 0;
    repeat (6) step();
    chk("midrx_no_tx", txq.size(), 0);
    m_mode = 0;
    m_seed = 1;
    m_err = 0;
    m_led = 0;
    do_led(32'h0000_0005);
    do_tx(2);
    do_stat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ft_test_engine.md
FT_TEST_ENGINE -- requirements
Module: ft_test_engine

Interface
REQ-001 Parameter DATA_W, default 8, FIFO data width; legal values are 8, 16 and 32.
REQ-002 Parameter LED_W, default 4, width of the LED output register.
REQ-003 Parameter CNT_W, default 32, width of the word counter and error counter; legal range is 16 to 32.
REQ-004 sys_clk  in  1  single clock; all logic is on its rising edge.
REQ-005 sys_rst  in  1  asynchronous active-high reset.
REQ-006 rxfifo_empty  in  1  RX FIFO holds no word.
REQ-007 rxfifo_rd  out  1  RX read strobe.
REQ-008 rxfifo_valid  in  1  rxfifo_data is valid; asserted exactly 1 cycle after an accepted rxfifo_rd.
REQ-009 rxfifo_data  in  DATA_W  RX word.
REQ-010 txfifo_full  in  1  TX FIFO cannot accept a word.
REQ-011 txfifo_wr  out  1  TX write request.
REQ-012 txfifo_data  out  DATA_W  TX word.
REQ-013 led  out  LED_W  LED register.
REQ-014 busy  out  1  high in any state other than CMD_WAIT.

Function
REQ-015 A TX word SHALL be transferred in any cycle with txfifo_wr=1 and txfifo_full=0; while txfifo_full=1, txfifo_wr and txfifo_data SHALL hold their values.
REQ-016 rxfifo_rd SHALL be asserted only when rxfifo_empty=0, with at most 1 read outstanding in command phase.
REQ-017 Command bytes SHALL be rxfifo_data[7:0] and SHALL shift into a 64-bit window {prefix, code[15:0], data[31:0], suffix}, with the newest byte entering at the MSB.
REQ-018 The window SHALL be checked 1 cycle after each byte; a frame is valid when prefix=8'hAA and suffix=8'h55.
REQ-019 An invalid frame SHALL leave the window intact (sliding resync) and return the FSM to CMD_WAIT.
REQ-020 FSM states SHALL be CMD_WAIT, CMD_READ, CMD_PARSE, TX_TEST, RX_TEST, RX_REPORT and STAT_SEND.
REQ-021 A valid frame SHALL clear the window; any unknown code SHALL return the FSM to CMD_WAIT.
REQ-022 Code 16'hBEEF SHALL emit exactly N=data[CNT_W-1:0] words in the current pattern mode, starting from the seed; N=0 emits nothing.
REQ-023 Code 16'hCAFE SHALL consume exactly N words using pipelined reads (rd = !empty && issued<N), compare each against the expected pattern, count mismatches saturating at all-ones, then enter RX_REPORT.
REQ-024 RX_REPORT SHALL write 1 word: 8'h42 on 0 errors, otherwise 8'hEE, zero-extended to DATA_W.
REQ-025 Code 16'h1ED0 SHALL load led <= data[LED_W-1:0].
REQ-026 Code 16'h0DE5 SHALL load mode <= data[1:0] and seed <= data[DATA_W-1:0] when DATA_W<=32.
REQ-027 Mode 0 SHALL be increment (+1 modulo 2^DATA_W).
REQ-028 Mode 1 SHALL be a Galois LFSR with the package taps; a zero seed SHALL be replaced by 1.
REQ-029 Mode 2 SHALL be walking-ones, rotate left by 1; a zero seed SHALL be replaced by 1.
REQ-030 Mode 3 SHALL behave as mode 0.
REQ-031 Code 16'h57A7 SHALL send the last RX error count as 4 words, least-significant byte first, each byte zero-extended to DATA_W.
REQ-032 Counters SHALL wrap silently, except the error counter, which SHALL saturate.
REQ-033 While in any test state, RX bytes SHALL be treated as test data and never parsed as commands.

Reset
REQ-034 On sys_rst=1, outputs SHALL immediately go to: rxfifo_rd=0, txfifo_wr=0, txfifo_data=0, led=0, busy=0.
REQ-035 On sys_rst=1, state SHALL go to CMD_WAIT, the window to 0, mode to 0, seed to 1, and the error counter to 0.
REQ-036 Reset asserted mid-test SHALL abort the test; no further reads or writes occur until a new command is received.

Structure
REQ-037 Package ft_test_pkg SHALL hold the state enum, the command code and prefix/suffix constants, the pass/fail words, the mode enum and the LFSR tap constants for 8, 16 and 32 bits.
REQ-038 Sub-module ft_pattern_gen SHALL provide the seed-load, advance and mode functions and SHALL be instantiated twice: once as TX generator and once as RX expected-value generator.

Verification
REQ-039 Frame AA EF BE 05 00 00 00 55 in mode 0 -> TX 00..04, then idle with busy=0.
REQ-040 Garbage byte 11, then a valid CAFE frame with N=3, followed by RX 00 01 02 -> exactly 1 TX word, 8'h42.
REQ-041 Same test with RX 00 FF 02, followed by a STAT frame -> TX 8'hEE, then 01 00 00 00.
REQ-042 Mode frame selecting LFSR with seed 0, then a BEEF frame with N=3 -> TX 01, then the next 2 LFSR states.
REQ-043 BEEF frame with N=4 while txfifo_full is toggled every cycle -> 4 words delivered in order, with no duplicates and no gaps.
REQ-044 Reset asserted during RX_TEST -> outputs go to 0 immediately, and a subsequent LED frame with data 5 -> led=5.
